// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared definitions for the multi-cycle RV32I-subset core.
//               Holds the opcode and funct3/funct7 constants, the FSM state
//               enum and the ALU operation enum.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Major opcodes (IR[6:0])
  localparam logic [6:0] C_OPC_OP     = 7'b0110011;  // R-type ALU
  localparam logic [6:0] C_OPC_OP_IMM = 7'b0010011;  // I-type ALU
  localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;  // conditional branch
  localparam logic [6:0] C_OPC_SYSTEM = 7'b1110011;  // ECALL and friends

  // funct3 encodings (IR[14:12])
  localparam logic [2:0] C_F3_ADD_SUB = 3'b000;
  localparam logic [2:0] C_F3_SLL     = 3'b001;
  localparam logic [2:0] C_F3_SLT     = 3'b010;
  localparam logic [2:0] C_F3_XOR     = 3'b100;
  localparam logic [2:0] C_F3_SRL_SRA = 3'b101;
  localparam logic [2:0] C_F3_OR      = 3'b110;
  localparam logic [2:0] C_F3_AND     = 3'b111;
  localparam logic [2:0] C_F3_BEQ     = 3'b000;
  localparam logic [2:0] C_F3_BNE     = 3'b001;

  // funct7 encodings (IR[31:25])
  localparam logic [6:0] C_F7_BASE = 7'h00;
  localparam logic [6:0] C_F7_ALT  = 7'h20;  // SUB / SRA

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_HALT      = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7,
    ALU_SRA = 4'd8
  } alu_op_e;

endpackage
`default_nettype wire

// File: rtl/cpu_alu.sv
`default_nettype none
// ============================================================================
// Module      : cpu_alu
// Description : Purely combinational ALU for the multi-cycle core.
// Ports       : op_i   - operation select (cpu_pkg::alu_op_e encoding)
//               a_i    - first operand
//               b_i    - second operand / shift amount source
//               y_o    - result
//               zero_o - result equals zero (branch compare)
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] y_o,
  output logic            zero_o
);

  localparam int C_SHW = $clog2(XLEN);

  // Only the low log2(XLEN) bits of B form the shift amount.
  logic [C_SHW-1:0] w_shamt;
  logic             w_lt;

  assign w_shamt = b_i[C_SHW-1:0];
  assign w_lt    = $signed(a_i) < $signed(b_i);

  always_comb begin
    y_o = '0;
    case (alu_op_e'(op_i))
      ALU_ADD: y_o = a_i + b_i;
      ALU_SUB: y_o = a_i - b_i;
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_XOR: y_o = a_i ^ b_i;
      ALU_SLT: y_o = {{(XLEN-1){1'b0}}, w_lt};
      ALU_SLL: y_o = a_i << w_shamt;
      ALU_SRL: y_o = a_i >> w_shamt;
      ALU_SRA: y_o = $signed(a_i) >>> w_shamt;
      default: y_o = '0;
    endcase
  end

  assign zero_o = (y_o == '0);

endmodule
`default_nettype wire

// File: rtl/multi_cycle_cpu.sv
`default_nettype none
// ============================================================================
// Module      : multi_cycle_cpu
// Description : Non-pipelined RV32I-subset core. Each instruction walks
//               FETCH -> DECODE -> EXECUTE -> WRITEBACK (4 cycles plus any
//               fetch wait). Illegal opcodes and ECALL park the core in HALT.
// Ports       : clk_i        - clock, rising edge
//               rst_i        - asynchronous active-high reset
//               imem_req_o   - fetch request, held until imem_ack_i
//               imem_addr_o  - fetch byte address (PC)
//               imem_ack_i   - fetch acknowledge, data valid same cycle
//               imem_rdata_i - fetched instruction word
//               halt_o       - core stopped
//               wb_valid_o   - one-cycle pulse per register write
//               wb_addr_o    - destination register of that write
//               wb_data_o    - value written
// Revision    : 1.0 - initial release
// ============================================================================
module multi_cycle_cpu
  import cpu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NREG     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            halt_o,
  output logic            wb_valid_o,
  output logic [4:0]      wb_addr_o,
  output logic [XLEN-1:0] wb_data_o
);

  localparam int              C_RIDX = $clog2(NREG);
  localparam logic [5:0]      C_NREG = 6'(NREG);
  localparam logic [XLEN-1:0] C_FOUR = XLEN'(4);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e          state_q,   state_d;
  logic [XLEN-1:0] pc_q,      pc_d;
  logic [31:0]     ir_q,      ir_d;
  logic [XLEN-1:0] a_q,       a_d;
  logic [XLEN-1:0] b_q,       b_d;
  logic [XLEN-1:0] imm_q,     imm_d;
  logic [XLEN-1:0] alu_out_q, alu_out_d;
  logic            taken_q,   taken_d;
  logic            wb_valid_q, wb_valid_d;
  logic [4:0]      wb_addr_q, wb_addr_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];

  // --------------------------------------------------------------------------
  // Instruction fields (IR is stable from DECODE through WRITEBACK)
  // --------------------------------------------------------------------------
  logic [6:0]      w_opcode;
  logic [4:0]      w_rd;
  logic [2:0]      w_funct3;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [6:0]      w_funct7;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_b;

  assign w_opcode = ir_q[6:0];
  assign w_rd     = ir_q[11:7];
  assign w_funct3 = ir_q[14:12];
  assign w_rs1    = ir_q[19:15];
  assign w_rs2    = ir_q[24:20];
  assign w_funct7 = ir_q[31:25];
  assign w_imm_i  = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
  assign w_imm_b  = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25],
                     ir_q[11:8], 1'b0};

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  logic    w_legal;
  logic    w_writes_rd;
  logic    w_uses_rs2;
  logic    w_is_imm;
  logic    w_is_branch;
  logic    w_regs_ok;
  alu_op_e w_alu_op;

  always_comb begin
    w_legal     = 1'b0;
    w_writes_rd = 1'b0;
    w_uses_rs2  = 1'b0;
    w_is_imm    = 1'b0;
    w_is_branch = 1'b0;
    w_alu_op    = ALU_ADD;
    case (w_opcode)
      C_OPC_OP: begin
        w_writes_rd = 1'b1;
        w_uses_rs2  = 1'b1;
        // funct7[5] (IR[30]) picks SUB/SRA; only those two accept it.
        case (w_funct3)
          C_F3_ADD_SUB: begin
            w_legal  = (w_funct7 == C_F7_BASE) || (w_funct7 == C_F7_ALT);
            w_alu_op = w_funct7[5] ? ALU_SUB : ALU_ADD;
          end
          C_F3_SRL_SRA: begin
            w_legal  = (w_funct7 == C_F7_BASE) || (w_funct7 == C_F7_ALT);
            w_alu_op = w_funct7[5] ? ALU_SRA : ALU_SRL;
          end
          C_F3_SLL: begin w_legal = (w_funct7 == C_F7_BASE); w_alu_op = ALU_SLL; end
          C_F3_SLT: begin w_legal = (w_funct7 == C_F7_BASE); w_alu_op = ALU_SLT; end
          C_F3_XOR: begin w_legal = (w_funct7 == C_F7_BASE); w_alu_op = ALU_XOR; end
          C_F3_OR:  begin w_legal = (w_funct7 == C_F7_BASE); w_alu_op = ALU_OR;  end
          C_F3_AND: begin w_legal = (w_funct7 == C_F7_BASE); w_alu_op = ALU_AND; end
          default:  w_legal = 1'b0;  // SLTU not supported
        endcase
      end
      C_OPC_OP_IMM: begin
        w_writes_rd = 1'b1;
        w_is_imm    = 1'b1;
        case (w_funct3)
          C_F3_ADD_SUB: begin w_legal = 1'b1; w_alu_op = ALU_ADD; end
          C_F3_SLT:     begin w_legal = 1'b1; w_alu_op = ALU_SLT; end
          C_F3_XOR:     begin w_legal = 1'b1; w_alu_op = ALU_XOR; end
          C_F3_OR:      begin w_legal = 1'b1; w_alu_op = ALU_OR;  end
          C_F3_AND:     begin w_legal = 1'b1; w_alu_op = ALU_AND; end
          default:      w_legal = 1'b0;  // immediate shifts, SLTIU
        endcase
      end
      C_OPC_BRANCH: begin
        w_uses_rs2  = 1'b1;
        w_is_branch = 1'b1;
        w_legal     = (w_funct3 == C_F3_BEQ) || (w_funct3 == C_F3_BNE);
        w_alu_op    = ALU_SUB;
      end
      // ECALL (C_OPC_SYSTEM) deliberately falls here: it stops the core
      // exactly like an unknown opcode.
      default: w_legal = 1'b0;
    endcase
  end

  // Register indices beyond the implemented file make the instruction illegal.
  assign w_regs_ok = ({1'b0, w_rs1} < C_NREG) &&
                     (!w_uses_rs2  || ({1'b0, w_rs2} < C_NREG)) &&
                     (!w_writes_rd || ({1'b0, w_rd}  < C_NREG));

  // --------------------------------------------------------------------------
  // ALU
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] w_alu_b;
  logic [XLEN-1:0] w_alu_y;
  logic            w_alu_zero;

  assign w_alu_b = w_is_imm ? imm_q : b_q;

  cpu_alu #(
    .XLEN (XLEN)
  ) u_alu (
    .op_i   (w_alu_op),
    .a_i    (a_q),
    .b_i    (w_alu_b),
    .y_o    (w_alu_y),
    .zero_o (w_alu_zero)
  );

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    a_d        = a_q;
    b_d        = b_q;
    imm_d      = imm_q;
    alu_out_d  = alu_out_q;
    taken_d    = taken_q;
    regs_d     = regs_q;
    wb_valid_d = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    case (state_q)
      ST_FETCH: begin
        if (imem_ack_i) begin
          ir_d    = imem_rdata_i;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        a_d     = regs_q[w_rs1[C_RIDX-1:0]];
        b_d     = regs_q[w_rs2[C_RIDX-1:0]];
        imm_d   = w_is_branch ? w_imm_b : w_imm_i;
        state_d = (w_legal && w_regs_ok) ? ST_EXECUTE : ST_HALT;
      end
      ST_EXECUTE: begin
        alu_out_d = w_alu_y;
        taken_d   = w_is_branch &&
                    ((w_funct3 == C_F3_BEQ) ? w_alu_zero : !w_alu_zero);
        state_d   = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        // x0 is never written, so regs_q[0] stays zero from reset.
        if (w_writes_rd && (w_rd != 5'd0)) begin
          regs_d[w_rd[C_RIDX-1:0]] = alu_out_q;
          wb_valid_d               = 1'b1;
          wb_addr_d                = w_rd;
          wb_data_d                = alu_out_q;
        end
        pc_d    = taken_q ? (pc_q + imm_q) : (pc_q + C_FOUR);
        state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      imm_q      <= '0;
      alu_out_q  <= '0;
      taken_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      a_q        <= a_d;
      b_q        <= b_d;
      imm_q      <= imm_d;
      alu_out_q  <= alu_out_d;
      taken_q    <= taken_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      regs_q     <= regs_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // The request is gated by rst_i so it drops the moment reset is applied,
  // and rises in the first cycle after reset is released.
  assign imem_req_o  = (state_q == ST_FETCH) && !rst_i;
  assign imem_addr_o = pc_q;
  assign halt_o      = (state_q == ST_HALT);
  assign wb_valid_o  = wb_valid_q;
  assign wb_addr_o   = wb_addr_q;
  assign wb_data_o   = wb_data_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_cpu.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_cycle_cpu
// Description : Self-checking bench for multi_cycle_cpu. Serves instruction
//               fetches with configurable ack delay and checks every fetch
//               address, write-back pulse and halt against an instruction-
//               level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_cycle_cpu;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic        halt_o;
  logic        wb_valid_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_data_o;

  multi_cycle_cpu #(
    .XLEN     (32),
    .NREG     (32),
    .RESET_PC (32'h0)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_rdata_i (imem_rdata_i),
    .halt_o       (halt_o),
    .wb_valid_o   (wb_valid_o),
    .wb_addr_o    (wb_addr_o),
    .wb_data_o    (wb_data_o)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  logic [31:0] m_reg [32];
  logic [31:0] m_pc;
  bit          exp_halt;
  bit          exp_wb;
  logic [4:0]  exp_rd;
  logic [31:0] exp_data;

  // Last observation from run_one
  logic        obs_valid;
  logic [4:0]  obs_rd;
  logic [31:0] obs_data;
  logic [31:0] obs_addr;
  int          t_req;
  int          t_end;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    logic [12:0] boff;
    int          k, o;
    rd   = 5'($urandom_range(0, 7));
    rs1  = 5'($urandom_range(0, 7));
    rs2  = 5'($urandom_range(0, 7));
    imm  = 12'($urandom);
    o    = int'($urandom_range(0, 15)) - 8;
    boff = 13'(o * 4);
    k    = int'($urandom_range(0, 15));
    case (k)
      0:  return enc_r(7'h00, rs2, rs1, 3'd0, rd);  // ADD
      1:  return enc_r(7'h20, rs2, rs1, 3'd0, rd);  // SUB
      2:  return enc_r(7'h00, rs2, rs1, 3'd1, rd);  // SLL
      3:  return enc_r(7'h00, rs2, rs1, 3'd2, rd);  // SLT
      4:  return enc_r(7'h00, rs2, rs1, 3'd4, rd);  // XOR
      5:  return enc_r(7'h00, rs2, rs1, 3'd5, rd);  // SRL
      6:  return enc_r(7'h20, rs2, rs1, 3'd5, rd);  // SRA
      7:  return enc_r(7'h00, rs2, rs1, 3'd6, rd);  // OR
      8:  return enc_r(7'h00, rs2, rs1, 3'd7, rd);  // AND
      9:  return enc_i(imm, rs1, 3'd0, rd);         // ADDI
      10: return enc_i(imm, rs1, 3'd2, rd);         // SLTI
      11: return enc_i(imm, rs1, 3'd4, rd);         // XORI
      12: return enc_i(imm, rs1, 3'd6, rd);         // ORI
      13: return enc_i(imm, rs1, 3'd7, rd);         // ANDI
      14: return enc_b(boff, rs1, rs2, 3'd0);       // BEQ
      default: return enc_b(boff, rs1, rs2, 3'd1);  // BNE
    endcase
  endfunction

  task automatic model_reset();
    m_pc = 32'h0;
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
  endtask

  // Architectural effect of one instruction, by mnemonic.
  task automatic model_exec(input logic [31:0] ins);
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] a, b, ii, bi, res;
    bit          legal, wr, tk;
    op  = ins[6:0];  rd  = ins[11:7];  f3 = ins[14:12];
    rs1 = ins[19:15]; rs2 = ins[24:20]; f7 = ins[31:25];
    a   = m_reg[rs1]; b = m_reg[rs2];
    ii  = {{20{ins[31]}}, ins[31:20]};
    bi  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    legal = 1'b1; wr = 1'b0; tk = 1'b0; res = 32'h0;
    case (op)
      7'h33: begin
        wr = 1'b1;
        case ({f7, f3})
          {7'h00, 3'd0}: res = a + b;
          {7'h20, 3'd0}: res = a - b;
          {7'h00, 3'd1}: res = a << b[4:0];
          {7'h00, 3'd2}: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          {7'h00, 3'd4}: res = a ^ b;
          {7'h00, 3'd5}: res = a >> b[4:0];
          {7'h20, 3'd5}: res = $signed(a) >>> b[4:0];
          {7'h00, 3'd6}: res = a | b;
          {7'h00, 3'd7}: res = a & b;
          default:       legal = 1'b0;
        endcase
      end
      7'h13: begin
        wr = 1'b1;
        case (f3)
          3'd0:    res = a + ii;
          3'd2:    res = ($signed(a) < $signed(ii)) ? 32'd1 : 32'd0;
          3'd4:    res = a ^ ii;
          3'd6:    res = a | ii;
          3'd7:    res = a & ii;
          default: legal = 1'b0;
        endcase
      end
      7'h63: begin
        case (f3)
          3'd0:    tk = (a == b);
          3'd1:    tk = (a != b);
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
    exp_halt = !legal;
    exp_wb   = legal && wr && (rd != 5'd0);
    exp_rd   = rd;
    exp_data = res;
    if (legal) begin
      if (exp_wb) m_reg[rd] = res;
      m_pc = tk ? (m_pc + bi) : (m_pc + 32'd4);
    end
  endtask

  // Serve one fetch (called at a negedge) and follow the instruction to the
  // next fetch request or to halt.
  task automatic run_one(input logic [31:0] ins, input int delay);
    int waited;
    waited = 0;
    while (imem_req_o !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("req_seen", 32'(imem_req_o), 32'd1);
    check("fetch_addr", imem_addr_o, m_pc);
    t_req = cyc;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("wait_req", 32'(imem_req_o), 32'd1);
      check("wait_addr_stable", imem_addr_o, m_pc);
    end
    imem_ack_i   = 1'b1;
    imem_rdata_i = ins;
    model_exec(ins);
    @(negedge clk);
    imem_ack_i   = 1'b0;
    imem_rdata_i = $urandom;
    check("decode_req", 32'(imem_req_o), 32'd0);
    check("decode_halt", 32'(halt_o), 32'd0);
    check("decode_wb", 32'(wb_valid_o), 32'd0);
    @(negedge clk);
    if (exp_halt) begin
      check("halt_set", 32'(halt_o), 32'd1);
      check("halt_req", 32'(imem_req_o), 32'd0);
      return;
    end
    check("exec_req", 32'(imem_req_o), 32'd0);
    check("exec_wb", 32'(wb_valid_o), 32'd0);
    @(negedge clk);
    check("wbst_req", 32'(imem_req_o), 32'd0);
    check("wbst_wb", 32'(wb_valid_o), 32'd0);
    @(negedge clk);
    t_end     = cyc;
    obs_valid = wb_valid_o;
    obs_rd    = wb_addr_o;
    obs_data  = wb_data_o;
    obs_addr  = imem_addr_o;
    check("next_req", 32'(imem_req_o), 32'd1);
    check("next_addr", imem_addr_o, m_pc);
    check("wb_valid", 32'(wb_valid_o), 32'(exp_wb));
    if (exp_wb) begin
      check("wb_addr", 32'(wb_addr_o), 32'(exp_rd));
      check("wb_data", wb_data_o, exp_data);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i      = 1'b1;
    imem_ack_i = 1'b0;
    #1;
    check("rst_req", 32'(imem_req_o), 32'd0);
    @(negedge clk);
    check("rst_halt", 32'(halt_o), 32'd0);
    check("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    check("rst_wb_addr", 32'(wb_addr_o), 32'd0);
    check("rst_wb_data", wb_data_o, 32'd0);
    check("rst_pc", imem_addr_o, 32'd0);
    rst_i = 1'b0;
    model_reset();
    @(negedge clk);
    check("first_req", 32'(imem_req_o), 32'd1);
  endtask

  initial begin
    rst_i        = 1'b1;
    imem_ack_i   = 1'b0;
    imem_rdata_i = 32'h0;
    model_reset();

    // Reset and the basic ADDI/ADDI/ADD sequence with zero-wait ack
    do_reset();
    run_one(enc_i(12'd5, 5'd0, 3'd0, 5'd1), 0);
    check("x1_is_5", obs_data, 32'd5);
    run_one(enc_i(12'hFFD, 5'd0, 3'd0, 5'd2), 0);
    check("x2_is_m3", obs_data, 32'hFFFF_FFFD);
    run_one(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 0);
    check("x3_is_2", obs_data, 32'd2);
    check("x3_rd", 32'(obs_rd), 32'd3);
    check("lat_3x4", 32'(t_end - t_req + 8), 32'd12);

    // Same program, every fetch acked after 3 wait cycles
    do_reset();
    run_one(enc_i(12'd5, 5'd0, 3'd0, 5'd1), 3);
    check("lat_wait_1", 32'(t_end - t_req), 32'd7);
    run_one(enc_i(12'hFFD, 5'd0, 3'd0, 5'd2), 3);
    run_one(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 3);
    check("x3_wait", obs_data, 32'd2);
    check("lat_wait_3", 32'(t_end - t_req), 32'd7);

    // Branches at PC 0x10 and 0x18
    do_reset();
    run_one(enc_i(12'd5, 5'd0, 3'd0, 5'd1), 0);
    run_one(enc_i(12'd5, 5'd0, 3'd0, 5'd2), 1);
    run_one(enc_i(12'd0, 5'd0, 3'd0, 5'd0), 0);
    run_one(enc_i(12'd0, 5'd0, 3'd0, 5'd0), 0);
    run_one(enc_b(13'd8, 5'd1, 5'd2, 3'd0), 0);
    check("beq_taken", obs_addr, 32'h18);
    run_one(enc_b(13'd8, 5'd1, 5'd2, 3'd1), 0);
    check("bne_not_taken", obs_addr, 32'h1C);

    // x0 write, signed SLT, arithmetic shift
    run_one(enc_i(12'd7, 5'd0, 3'd0, 5'd0), 0);
    check("x0_no_pulse", 32'(obs_valid), 32'd0);
    run_one(enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd7), 0);
    check("x0_reads_0", obs_data, 32'd0);
    run_one(enc_i(12'hFFF, 5'd0, 3'd0, 5'd1), 0);
    run_one(enc_i(12'd1, 5'd0, 3'd0, 5'd2), 0);
    run_one(enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd4), 0);
    check("slt_signed", obs_data, 32'd1);
    run_one(enc_i(12'd1, 5'd0, 3'd0, 5'd8), 0);
    run_one(enc_i(12'd31, 5'd0, 3'd0, 5'd9), 0);
    run_one(enc_r(7'h00, 5'd9, 5'd8, 3'd1, 5'd8), 2);
    check("sll_31", obs_data, 32'h8000_0000);
    run_one(enc_i(12'd4, 5'd0, 3'd0, 5'd10), 0);
    run_one(enc_r(7'h20, 5'd10, 5'd8, 3'd5, 5'd11), 0);
    check("sra_4", obs_data, 32'hF800_0000);

    // PC wrap-around: branch back to 0xFFFF_FFFC, then fall through to 0
    do_reset();
    run_one(enc_b(13'h1FFC, 5'd0, 5'd0, 3'd0), 0);
    check("pc_to_top", obs_addr, 32'hFFFF_FFFC);
    run_one(enc_i(12'd1, 5'd0, 3'd0, 5'd1), 0);
    check("pc_wrap", obs_addr, 32'h0);

    // Randomized program against the model
    do_reset();
    for (int n = 0; n < 250; n++) begin
      run_one(rand_instr(), int'($urandom_range(0, 3)));
    end

    // Reset while a fetch waits for ack; registers must come back zero
    @(negedge clk);
    #2;
    rst_i = 1'b1;
    #1;
    check("async_req_drop", 32'(imem_req_o), 32'd0);
    check("async_pc", imem_addr_o, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    model_reset();
    run_one(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 0);
    check("regs_cleared", obs_data, 32'd0);
    check("regs_cleared_v", 32'(obs_valid), 32'd1);

    // ECALL halts; halt absorbs further acks until reset
    run_one(32'h0000_0073, 0);
    for (int i = 0; i < 4; i++) begin
      imem_ack_i   = 1'b1;
      imem_rdata_i = enc_i(12'd9, 5'd0, 3'd0, 5'd5);
      @(negedge clk);
      check("halt_hold", 32'(halt_o), 32'd1);
      check("halt_no_req", 32'(imem_req_o), 32'd0);
      check("halt_no_wb", 32'(wb_valid_o), 32'd0);
    end
    imem_ack_i = 1'b0;
    do_reset();
    check("restart_addr", imem_addr_o, 32'h0);
    run_one(enc_r(7'h00, 5'd0, 5'd5, 3'd0, 5'd6), 0);
    check("halt_no_write", obs_data, 32'd0);

    // Unknown opcode 0x7F halts as well
    run_one(32'h0000_007F, 1);
    @(negedge clk);
    check("illegal_hold", 32'(halt_o), 32'd1);
    check("illegal_no_req", 32'(imem_req_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
